// File: rtl/mult_exhaustive_checker_pkg.sv
// Shared definitions for the exhaustive multiplier checker: sweep FSM states
// and the width helpers used by the top and its difference unit.
package mult_exhaustive_checker_pkg;

    localparam int DEFAULT_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int pw_f(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_w_f(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w_f(input int w);
        return 4 * w;
    endfunction

    function automatic int npairs_f(input int w);
        return 1 << (2 * w);
    endfunction

endpackage

// File: rtl/mult_abs_diff.sv
// Exact reference product of the current operand pair and the unsigned
// distance between the candidate product and that reference.
module mult_abs_diff
    import mult_exhaustive_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [2*WIDTH-1:0]     p,
    output logic [2*WIDTH-1:0]     prod,
    output logic [2*WIDTH-1:0]     diff
);

    localparam int PW = pw_f(WIDTH);

    // Reference product and ordered subtraction so the result never wraps.
    always_comb begin
        prod = PW'(a) * PW'(b);
        if (p >= prod) begin
            diff = p - prod;
        end else begin
            diff = prod - p;
        end
    end

endmodule

// File: rtl/mult_exhaustive_checker.sv
// Sweeps every operand pair through a combinational candidate multiplier and
// accumulates mismatch count, total/maximum absolute error and first failure.
module mult_exhaustive_checker
    import mult_exhaustive_checker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [WIDTH-1:0]       dut_a,
    output logic [WIDTH-1:0]       dut_b,
    input  logic [2*WIDTH-1:0]     dut_p,
    output logic                   busy,
    output logic                   done,
    output logic [2*WIDTH:0]       err_count,
    output logic [4*WIDTH-1:0]     sum_abs_err,
    output logic [2*WIDTH-1:0]     max_abs_err,
    output logic                   first_err_valid,
    output logic [WIDTH-1:0]       first_err_a,
    output logic [WIDTH-1:0]       first_err_b
);

    localparam int PW    = pw_f(WIDTH);
    localparam int CNT_W = cnt_w_f(WIDTH);
    localparam int SUM_W = sum_w_f(WIDTH);

    state_t             state_r;
    state_t             state_next_s;
    logic [PW-1:0]      idx_r;
    logic [PW-1:0]      prod_s;
    logic [PW-1:0]      diff_s;
    logic               start_accept_s;
    logic               mismatch_s;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   err_count_r;
    logic [SUM_W-1:0]   sum_abs_err_r;
    logic [PW-1:0]      max_abs_err_r;
    logic               first_err_valid_r;
    logic [WIDTH-1:0]   first_err_a_r;
    logic [WIDTH-1:0]   first_err_b_r;

    mult_abs_diff #(.WIDTH(WIDTH)) u_abs_diff (
        .a    (dut_a),
        .b    (dut_b),
        .p    (dut_p),
        .prod (prod_s),
        .diff (diff_s)
    );

    assign start_accept_s = start && (state_r != RUN);
    assign mismatch_s     = (dut_p != prod_s);

    // Next-state logic; a start during RUN is deliberately ignored.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (&idx_r) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (start_accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand counter and error accumulators; idx wraps to 0 after the last pair.
    always_ff @(posedge clk) begin
        if (rst || start_accept_s) begin
            idx_r             <= '0;
            err_count_r       <= '0;
            sum_abs_err_r     <= '0;
            max_abs_err_r     <= '0;
            first_err_valid_r <= 1'b0;
            first_err_a_r     <= '0;
            first_err_b_r     <= '0;
        end else if (state_r == RUN) begin
            idx_r <= idx_r + PW'(1);
            if (mismatch_s) begin
                err_count_r   <= err_count_r + CNT_W'(1);
                sum_abs_err_r <= sum_abs_err_r + SUM_W'(diff_s);
                if (diff_s > max_abs_err_r) begin
                    max_abs_err_r <= diff_s;
                end
                if (!first_err_valid_r) begin
                    first_err_valid_r <= 1'b1;
                    first_err_a_r     <= dut_a;
                    first_err_b_r     <= dut_b;
                end
            end
        end
    end

    assign dut_a           = idx_r[WIDTH-1:0];
    assign dut_b           = idx_r[PW-1:WIDTH];
    assign busy            = busy_r;
    assign done            = done_r;
    assign err_count       = err_count_r;
    assign sum_abs_err     = sum_abs_err_r;
    assign max_abs_err     = max_abs_err_r;
    assign first_err_valid = first_err_valid_r;
    assign first_err_a     = first_err_a_r;
    assign first_err_b     = first_err_b_r;

endmodule
